risky_memarb: RTL and testbench

//  Memory-side responder for the core's two bus initiators: instruction fetch (if_*) and load/store (ls_*).

---
 rtl/risky_memarb.sv | 200 ++++++++++++++++++++
 tb/tb_risky_memarb.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risky_memarb.sv
// ---------------------------------------------------------------------------
// risky_memarb
//   Memory-side responder for the core's two bus initiators, instruction
//   fetch (if_*) and load/store (ls_*). Both are arbitrated onto a single
//   single-port synchronous RAM (mem_*). stall is raised to the pipeline
//   while any request is still waiting for its ack.
//
//   Build option: RISKY_MEMARB_ALIGN_CHECK_EN
//     defined   : a granted access with addr[1:0] != 0 skips the RAM and is
//                 acked with err=1 and rdata=0; stores are dropped.
//     undefined : addr[1:0] is ignored and err is tied low.
//
// Parameters
//   ADDR_W  RAM word-address width (depth = 2**ADDR_W words)
//   DATA_W  data width
//
// Ports
//   clk, rst_n            clock (posedge), asynchronous active-low reset
//   if_req/if_addr        fetch request and byte address
//   if_ack/if_rdata       fetch ack pulse and fetched word
//   ls_req/ls_we/ls_addr/ls_wdata  load/store request, direction, address, data
//   ls_ack/ls_rdata       load/store ack pulse and loaded word
//   err                   qualifies if_ack/ls_ack: access rejected
//   stall                 a request is pending and not yet acked
//   mem_en/mem_we/mem_addr/mem_wdata  RAM strobe, write enable, word addr, data
//   mem_rdata             RAM read data, valid the cycle after mem_en
//
// Handshake: an initiator raises req and keeps req/addr/we/wdata stable
// until it sees its ack. ack is a one-cycle pulse; rdata and err are valid
// in that same cycle and rdata holds its value afterwards. The acked port's
// req is not looked at in the ack cycle, so it may drop req after that edge.
//
// FSM: IDLE -> ACCESS (mem_en high) -> RESP (ack). From RESP the other
// port is granted directly if it is requesting, giving one ack every two
// cycles under contention. The current state is visible on state_q.
// ---------------------------------------------------------------------------
module risky_memarb #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [31:0]       ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              err,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Attributes of the access in flight, captured at grant time.
  logic              owner_ls_q;
  logic              we_q;
  logic              mis_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;

  // Grant decision for the current cycle.
  logic              grant;
  logic              grant_ls;
  logic              g_we;
  logic [31:0]       g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              g_mis;

  logic resp_if;
  logic resp_ls;

  // ---------------------------------------------------------------------------
  // Next state and grant selection
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    grant_ls = 1'b0;
    case (state_q)
      IDLE: begin
        // load/store has priority when both ask at once
        if (ls_req) begin
          grant    = 1'b1;
          grant_ls = 1'b1;
        end else if (if_req) begin
          grant = 1'b1;
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      RESP: begin
        // Only the other port may be granted here; the port being acked
        // still has req high this cycle and must not be served twice.
        if (owner_ls_q && if_req) begin
          grant = 1'b1;
        end else if (!owner_ls_q && ls_req) begin
          grant    = 1'b1;
          grant_ls = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_q == IDLE || state_q == RESP) begin
      state_d = grant ? ACCESS : IDLE;
    end
  end

  assign g_we    = grant_ls & ls_we;
  assign g_addr  = grant_ls ? ls_addr : if_addr;
  assign g_wdata = grant_ls ? ls_wdata : '0;

`ifdef RISKY_MEMARB_ALIGN_CHECK_EN
  assign g_mis = (g_addr[1:0] != 2'b00);
`else
  assign g_mis = 1'b0;
`endif

  // Address bits above the RAM and (without the align check) the byte
  // offset take no part in the access.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{g_addr[31:ADDR_W+2], g_addr[1:0]};

  // ---------------------------------------------------------------------------
  // State and RAM-side registers. mem_en/mem_we are registered so that an
  // asynchronous reset in the ACCESS cycle drops them at once and an
  // in-flight store never commits.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_ls_q <= 1'b0;
      we_q       <= 1'b0;
      mis_q      <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      mem_en  <= grant & ~g_mis;
      mem_we  <= grant & g_we & ~g_mis;
      if (grant) begin
        owner_ls_q <= grant_ls;
        we_q       <= g_we;
        mis_q      <= g_mis;
        mem_addr   <= g_addr[ADDR_W+1:2];
        mem_wdata  <= g_wdata;
      end
      if (resp_if) begin
        if_rdata_q <= mis_q ? '0 : mem_rdata;
      end
      if (resp_ls) begin
        if (mis_q) begin
          ls_rdata_q <= '0;
        end else if (!we_q) begin
          ls_rdata_q <= mem_rdata;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Responses. The RAM word is only valid during RESP, so it is passed
  // through in the ack cycle and held in the rdata register afterwards.
  // ---------------------------------------------------------------------------
  assign resp_if = (state_q == RESP) && !owner_ls_q;
  assign resp_ls = (state_q == RESP) && owner_ls_q;

  assign if_ack = resp_if;
  assign ls_ack = resp_ls;
  assign err    = (state_q == RESP) && mis_q;

  assign if_rdata = resp_if ? (mis_q ? '0 : mem_rdata) : if_rdata_q;
  assign ls_rdata = resp_ls ? (mis_q ? '0 : (we_q ? ls_rdata_q : mem_rdata))
                            : ls_rdata_q;

  assign stall = (if_req & ~if_ack) | (ls_req & ~ls_ack);

endmodule

// File: tb/tb_risky_memarb.sv
// ---------------------------------------------------------------------------
// tb_risky_memarb
//   Bench for risky_memarb. A behavioural RAM sits on the mem_* side; the
//   expected contents live in model_mem, indexed by byte address / 4 modulo
//   the RAM depth, and expected timings follow the req -> mem_en -> ack
//   cycle counts of the arbiter.
// ---------------------------------------------------------------------------
module tb_risky_memarb;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

`ifdef RISKY_MEMARB_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              if_req = 1'b0;
  logic [31:0]       if_addr = '0;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req = 1'b0;
  logic              ls_we = 1'b0;
  logic [31:0]       ls_addr = '0;
  logic [DATA_W-1:0] ls_wdata = '0;
  logic              ls_ack;
  logic [DATA_W-1:0] ls_rdata;
  logic              err;
  logic              stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  risky_memarb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .err(err), .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // Behavioural RAM (environment), preloaded with init_val on ram_load
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] ram [0:DEPTH-1];
  logic              ram_load = 1'b0;

  function automatic logic [31:0] init_val(input int i);
    if (i == 2) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B9) ^ 32'h0F1E2D3C;
  endfunction

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard state
  // ---------------------------------------------------------------------------
  logic [31:0] model_mem [0:DEPTH-1];
  logic [31:0] exp_if_rd;
  logic [31:0] exp_ls_rd;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit is_mis(input logic [31:0] a);
    return ALIGN && (a[1:0] != 2'b00);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver / checker: one access from one port, with cycle-exact checks
  // ---------------------------------------------------------------------------
  task automatic single(input bit is_ls, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input string name);
    int idx;
    bit mis;
    idx = widx(addr);
    mis = is_mis(addr);
    @(posedge clk); #1;
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    // cycle N: request pending, nothing granted yet
    @(negedge clk);
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL %s stall@N got %0b want 1", name, stall); end
    n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL %s mem_en@N got %0b want 0", name, mem_en); end
    // cycle N+1: RAM access
    @(negedge clk);
    n_vec++; if (mem_en !== logic'(!mis)) begin n_err++; $display("FAIL %s mem_en@N+1 got %0b want %0b", name, mem_en, !mis); end
    if (!mis) begin
      n_vec++; if (mem_addr !== ADDR_W'(idx)) begin n_err++; $display("FAIL %s mem_addr got %0h want %0h", name, mem_addr, idx); end
      n_vec++; if (mem_we !== logic'(is_ls && we)) begin n_err++; $display("FAIL %s mem_we got %0b want %0b", name, mem_we, is_ls && we); end
      if (is_ls && we) begin
        n_vec++; if (mem_wdata !== wdata) begin n_err++; $display("FAIL %s mem_wdata got %0h want %0h", name, mem_wdata, wdata); end
      end
    end
    n_vec++; if ({if_ack, ls_ack} !== 2'b00) begin n_err++; $display("FAIL %s early ack got %b want 00", name, {if_ack, ls_ack}); end
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL %s stall@N+1 got %0b want 1", name, stall); end
    // cycle N+2: ack
    @(negedge clk);
    if (is_ls) begin
      if (mis) exp_ls_rd = '0;
      else if (!we) exp_ls_rd = model_mem[idx];
      else model_mem[idx] = wdata;
      n_vec++; if ({if_ack, ls_ack} !== 2'b01) begin n_err++; $display("FAIL %s acks got %b want 01", name, {if_ack, ls_ack}); end
      n_vec++; if (ls_rdata !== exp_ls_rd) begin n_err++; $display("FAIL %s ls_rdata got %0h want %0h", name, ls_rdata, exp_ls_rd); end
    end else begin
      exp_if_rd = mis ? '0 : model_mem[idx];
      n_vec++; if ({if_ack, ls_ack} !== 2'b10) begin n_err++; $display("FAIL %s acks got %b want 10", name, {if_ack, ls_ack}); end
      n_vec++; if (if_rdata !== exp_if_rd) begin n_err++; $display("FAIL %s if_rdata got %0h want %0h", name, if_rdata, exp_if_rd); end
    end
    n_vec++; if (err !== logic'(mis)) begin n_err++; $display("FAIL %s err got %0b want %0b", name, err, mis); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL %s stall@ack got %0b want 0", name, stall); end
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    n_vec++; if ({if_ack, ls_ack, mem_en} !== 3'b000) begin n_err++; $display("FAIL %s after ack got %b want 000", name, {if_ack, ls_ack, mem_en}); end
    n_vec++; if (ls_rdata !== exp_ls_rd || if_rdata !== exp_if_rd) begin n_err++; $display("FAIL %s held rdata got %0h/%0h want %0h/%0h", name, if_rdata, ls_rdata, exp_if_rd, exp_ls_rd); end
  endtask

  // Both ports raise req in the same cycle: ls is served first, fetch next.
  task automatic both(input bit we, input logic [31:0] la, input logic [31:0] wd,
                      input logic [31:0] fa, input string name);
    int  li, fi;
    bit  lm, fm;
    li = widx(la); fi = widx(fa);
    lm = is_mis(la); fm = is_mis(fa);
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = we; ls_addr = la; ls_wdata = wd;
    if_req = 1'b1; if_addr = fa;
    @(negedge clk);  // N
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL %s stall@N got %0b want 1", name, stall); end
    @(negedge clk);  // N+1: ls access
    n_vec++; if (mem_en !== logic'(!lm)) begin n_err++; $display("FAIL %s ls mem_en got %0b want %0b", name, mem_en, !lm); end
    if (!lm) begin
      n_vec++; if ({mem_we, mem_addr} !== {logic'(we), ADDR_W'(li)}) begin n_err++; $display("FAIL %s ls we/addr got %0b/%0h want %0b/%0h", name, mem_we, mem_addr, we, li); end
    end
    @(negedge clk);  // N+2: ls ack
    if (lm) exp_ls_rd = '0;
    else if (!we) exp_ls_rd = model_mem[li];
    else model_mem[li] = wd;
    n_vec++; if ({if_ack, ls_ack} !== 2'b01) begin n_err++; $display("FAIL %s first acks got %b want 01", name, {if_ack, ls_ack}); end
    n_vec++; if (ls_rdata !== exp_ls_rd) begin n_err++; $display("FAIL %s ls_rdata got %0h want %0h", name, ls_rdata, exp_ls_rd); end
    n_vec++; if (err !== logic'(lm)) begin n_err++; $display("FAIL %s ls err got %0b want %0b", name, err, lm); end
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL %s stall@N+2 got %0b want 1", name, stall); end
    @(posedge clk); #1;
    ls_req = 1'b0;
    @(negedge clk);  // N+3: fetch access, no idle gap
    n_vec++; if (mem_en !== logic'(!fm)) begin n_err++; $display("FAIL %s if mem_en got %0b want %0b", name, mem_en, !fm); end
    if (!fm) begin
      n_vec++; if ({mem_we, mem_addr} !== {1'b0, ADDR_W'(fi)}) begin n_err++; $display("FAIL %s if we/addr got %0b/%0h want 0/%0h", name, mem_we, mem_addr, fi); end
    end
    n_vec++; if ({if_ack, ls_ack} !== 2'b00) begin n_err++; $display("FAIL %s acks@N+3 got %b want 00", name, {if_ack, ls_ack}); end
    @(negedge clk);  // N+4: fetch ack
    exp_if_rd = fm ? '0 : model_mem[fi];
    n_vec++; if ({if_ack, ls_ack} !== 2'b10) begin n_err++; $display("FAIL %s second acks got %b want 10", name, {if_ack, ls_ack}); end
    n_vec++; if (if_rdata !== exp_if_rd) begin n_err++; $display("FAIL %s if_rdata got %0h want %0h", name, if_rdata, exp_if_rd); end
    n_vec++; if (err !== logic'(fm)) begin n_err++; $display("FAIL %s if err got %0b want %0b", name, err, fm); end
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    n_vec++; if ({if_ack, ls_ack, mem_en} !== 3'b000) begin n_err++; $display("FAIL %s tail got %b want 000", name, {if_ack, ls_ack, mem_en}); end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    logic [31:0] old;
    @(negedge clk);
    n_vec++; if ({if_ack, ls_ack, err, mem_en, mem_we, stall} !== 6'b0) begin n_err++; $display("FAIL reset ctl got %b want 000000", {if_ack, ls_ack, err, mem_en, mem_we, stall}); end
    n_vec++; if ({if_rdata, ls_rdata} !== 64'h0) begin n_err++; $display("FAIL reset rdata got %0h/%0h want 0/0", if_rdata, ls_rdata); end
    n_vec++; if ({mem_addr, mem_wdata} !== {ADDR_W'(0), 32'h0}) begin n_err++; $display("FAIL reset mem got %0h/%0h want 0/0", mem_addr, mem_wdata); end
    @(negedge clk); rst_n = 1'b1;
    // store to 0x10 aborted by reset in its ACCESS cycle
    old = model_mem[4];
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h10; ls_wdata = ~old;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL abort store mem_we@access got %0b want 1", mem_we); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({mem_en, mem_we, ls_ack} !== 3'b000) begin n_err++; $display("FAIL abort async clear got %b want 000", {mem_en, mem_we, ls_ack}); end
    ls_req = 1'b0; ls_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if ({if_ack, ls_ack} !== 2'b00) begin n_err++; $display("FAIL abort ack got %b want 00", {if_ack, ls_ack}); end
    end
    rst_n = 1'b1;
    exp_ls_rd = '0; exp_if_rd = '0;
    single(1'b1, 1'b0, 32'h10, 32'h0, "abort readback");
  endtask

  task automatic test_fetch;
    single(1'b0, 1'b0, 32'h8, 32'h0, "fetch 0x8");
    n_vec++; if (if_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL fetch const got %0h want deadbeef", if_rdata); end
  endtask

  task automatic test_store_load;
    single(1'b1, 1'b1, 32'h4, 32'h1234, "store 0x4");
    single(1'b1, 1'b0, 32'h4, 32'h0, "load 0x4");
    n_vec++; if (ls_rdata !== 32'h1234) begin n_err++; $display("FAIL load const got %0h want 1234", ls_rdata); end
  endtask

  task automatic test_contention;
    both(1'b0, 32'h4, 32'h0, 32'h8, "contend load/fetch");
    both(1'b1, 32'h20, 32'hCAFE0001, 32'h20, "contend store/fetch same");
  endtask

  task automatic test_wrap;
    single(1'b1, 1'b0, 32'h1004, 32'h0, "wrap 0x1004");
    n_vec++; if (ls_rdata !== 32'h1234) begin n_err++; $display("FAIL wrap alias got %0h want 1234", ls_rdata); end
    single(1'b1, 1'b1, 32'hFFFF_F008, 32'h5555AAAA, "wrap store high");
    single(1'b0, 1'b0, 32'h8, 32'h0, "wrap fetch low");
  endtask

  task automatic test_misaligned;
    single(1'b1, 1'b0, 32'h6, 32'h0, "misaligned load 0x6");
    single(1'b1, 1'b1, 32'h9, 32'h77777777, "misaligned store 0x9");
    single(1'b0, 1'b0, 32'h9, 32'h0, "misaligned readback 0x9");
  endtask

  task automatic test_back_to_back;
    for (int it = 0; it < 60; it++) begin
      logic [31:0] a1, a2, d;
      bit          w;
      a1 = {$urandom_range(0, 3) == 0 ? 20'($urandom) : 20'h0, 10'($urandom_range(0, 31)), 2'b00};
      a2 = {20'h0, 10'($urandom_range(0, 31)), 2'b00};
      if ($urandom_range(0, 7) == 0) a1[1:0] = 2'($urandom_range(1, 3));
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       single(1'b1, w, a1, d, "rand ls");
        1:       single(1'b0, 1'b0, a1, 32'h0, "rand if");
        default: both(w, a1, d, a2, "rand both");
      endcase
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = init_val(i);
    exp_if_rd = '0;
    exp_ls_rd = '0;
    rst_n = 1'b0;
    ram_load = 1'b1;
    @(posedge clk); #1;
    ram_load = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_fetch();
    test_store_load();
    test_contention();
    test_wrap();
    test_misaligned();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
